// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and radix-4 Booth recoding for the sequential multiplier
package booth_pkg;

  typedef struct packed {
    logic zero;
    logic neg;
    logic two;
  } boothDigit_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic boothDigit_t boothRecode(input logic [2:0] trip);
    boothDigit_t d;
    d = '{zero: 1'b0, neg: 1'b0, two: 1'b0};
    case (trip)
      3'b000, 3'b111: d.zero = 1'b1;
      3'b011:         d.two  = 1'b1;
      3'b100: begin
        d.neg = 1'b1;
        d.two = 1'b1;
      end
      3'b101, 3'b110: d.neg = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_pp_gen.sv
// rtl/booth_r4_pp_gen.sv - one's-complement partial product and carry-in for one Booth digit
module booth_r4_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   i_a_ext,
  input  boothDigit_t      i_digit,
  output logic [WIDTH+2:0] o_pp,
  output logic             o_neg
);

  logic [WIDTH+2:0] w_mag;

  always_comb begin
    w_mag = '0;
    if (i_digit.zero)
      w_mag = '0;
    else if (i_digit.two)
      w_mag = {i_a_ext[WIDTH], i_a_ext, 1'b0};
    else
      w_mag = {{2{i_a_ext[WIDTH]}}, i_a_ext};
    // Negation completes in the accumulator adder via o_neg as the +1.
    o_pp  = i_digit.neg ? ~w_mag : w_mag;
    o_neg = i_digit.neg & ~i_digit.zero;
  end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// rtl/booth_r4_seq_mult.sv - iterative radix-4 Booth multiplier, one digit per cycle
module booth_r4_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               inValid,
  output logic               inReady,
  input  logic               signedFlag,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               outValid,
  input  logic               outReady,
  output logic [2*WIDTH-1:0] product
);

  localparam int NDIG = WIDTH / 2 + 1;
  localparam int CW   = $clog2(NDIG);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH:0]     r_a_ext;
  logic [WIDTH+2:0]   r_b_ext;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;

  logic [WIDTH+2:0]   w_b_shift;
  boothDigit_t        w_digit;
  logic [WIDTH+2:0]   w_pp;
  logic               w_neg;
  logic [2*WIDTH-1:0] w_pp_ext;
  logic [2*WIDTH-1:0] w_neg_ext;
  logic [2*WIDTH-1:0] w_sum;
  logic               w_last;

  // r_b_ext carries the implicit zero below bit 0, so digit i sits at [2i+2:2i].
  assign w_b_shift = r_b_ext >> {r_cnt, 1'b0};
  assign w_digit   = boothRecode(w_b_shift[2:0]);
  assign w_last    = (r_cnt == CW'(NDIG - 1));

  booth_r4_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
    .i_a_ext (r_a_ext),
    .i_digit (w_digit),
    .o_pp    (w_pp),
    .o_neg   (w_neg)
  );

  assign w_pp_ext  = {{(WIDTH - 3){w_pp[WIDTH+2]}}, w_pp};
  assign w_neg_ext = {{(2*WIDTH - 1){1'b0}}, w_neg};
  assign w_sum     = r_acc + (w_pp_ext << {r_cnt, 1'b0}) + (w_neg_ext << {r_cnt, 1'b0});

  always_ff @(posedge clk) begin
    if (!rstN) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    inReady  = 1'b0;
    outValid = 1'b0;
    case (r_state)
      IDLE: begin
        inReady = 1'b1;
        if (inValid) w_next = BUSY;
      end
      BUSY: if (w_last) w_next = DONE;
      DONE: begin
        outValid = 1'b1;
        if (outReady) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_a_ext <= '0;
      r_b_ext <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        IDLE: if (inValid) begin
          r_a_ext <= {signedFlag & a[WIDTH-1], a};
          r_b_ext <= {{2{signedFlag & b[WIDTH-1]}}, b, 1'b0};
          r_cnt   <= '0;
          r_acc   <= '0;
        end
        BUSY: begin
          r_acc <= w_sum;
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign product = r_acc;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// tb/tb_booth_r4_seq_mult.sv - directed and randomized checks of booth_r4_seq_mult at several widths
module tb_booth_r4_seq_mult;

  logic clk = 1'b0;
  logic rstN, v, r, s;
  logic [3:0]  a4,  b4;
  logic [7:0]  a8,  b8;
  logic [15:0] a16, b16;
  logic [31:0] a32, b32;
  logic i4r, i8r, i16r, i32r, o4v, o8v, o16v, o32v;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic [31:0] p16;
  logic [63:0] p32;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  booth_r4_seq_mult #(.WIDTH(4)) u4 (.clk(clk), .rstN(rstN), .inValid(v), .inReady(i4r),
    .signedFlag(s), .a(a4), .b(b4), .outValid(o4v), .outReady(r), .product(p4));
  booth_r4_seq_mult #(.WIDTH(8)) u8 (.clk(clk), .rstN(rstN), .inValid(v), .inReady(i8r),
    .signedFlag(s), .a(a8), .b(b8), .outValid(o8v), .outReady(r), .product(p8));
  booth_r4_seq_mult #(.WIDTH(16)) u16 (.clk(clk), .rstN(rstN), .inValid(v), .inReady(i16r),
    .signedFlag(s), .a(a16), .b(b16), .outValid(o16v), .outReady(r), .product(p16));
  booth_r4_seq_mult #(.WIDTH(32)) u32 (.clk(clk), .rstN(rstN), .inValid(v), .inReady(i32r),
    .signedFlag(s), .a(a32), .b(b32), .outValid(o32v), .outReady(r), .product(p32));

  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic sg);
    longint sx, sy;
    logic [63:0] p, m;
    sx = longint'({32'b0, x});
    sy = longint'({32'b0, y});
    if (sg && x[w-1]) sx = sx - (longint'(1) << w);
    if (sg && y[w-1]) sy = sy - (longint'(1) << w);
    p = 64'(sx * sy);
    m = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    return p & m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic sf);
    @(negedge clk);
    chk("issue_ready", 64'(i8r), 64'd1);
    a8 = x; b8 = y; s = sf; v = 1'b1;
    @(posedge clk); #1;
    v = 1'b0;
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic sf,
                      input logic [15:0] exp, input string tag);
    issue8(x, y, sf);
    repeat (4) @(posedge clk);
    #1 chk({tag, "_valid_early"}, 64'(o8v), 64'd0);
    @(posedge clk);
    #1 chk({tag, "_valid_lat"}, 64'(o8v), 64'd1);
    chk(tag, 64'(p8), 64'(exp));
    r = 1'b1;
    @(posedge clk);
    #1 r = 1'b0;
    chk({tag, "_popped"}, 64'(o8v), 64'd0);
    chk({tag, "_ready_after"}, 64'(i8r), 64'd1);
  endtask

  initial begin
    logic [63:0] e4, e8, e16, e32;
    logic d4, d8, d16, d32;
    int cyc;
    rstN = 1'b0; v = 1'b0; r = 1'b0; s = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0; a32 = '0; b32 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inReady", 64'(i8r), 64'd1);
    chk("rst_outValid", 64'(o8v), 64'd0);
    chk("rst_product", 64'(p8), 64'd0);
    rstN = 1'b1;

    run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ff_ff");
    run8(8'h80, 8'h80, 1'b1, 16'h4000, "s_80_80");
    run8(8'h80, 8'h7F, 1'b1, 16'hC080, "s_80_7f");
    run8(8'h80, 8'h02, 1'b1, 16'hFF00, "s_80_02");
    run8(8'h80, 8'h02, 1'b0, 16'h0100, "u_80_02");

    // Backpressure: product must hold and new operands must be ignored.
    issue8(8'h12, 8'h34, 1'b0);
    repeat (5) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); v = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_valid", 64'(o8v), 64'd1);
      chk("bp_product", 64'(p8), 64'h03A8);
      chk("bp_inReady", 64'(i8r), 64'd0);
    end
    @(negedge clk);
    v = 1'b0; r = 1'b1;
    @(posedge clk);
    #1 r = 1'b0;
    chk("bp_popped", 64'(o8v), 64'd0);
    chk("bp_ready_after", 64'(i8r), 64'd1);
    @(posedge clk);
    #1 chk("bp_no_accept", 64'(i8r), 64'd1);

    // Reset while digit 2 is being accumulated.
    issue8(8'hAB, 8'hCD, 1'b0);
    repeat (2) @(posedge clk);
    #1 rstN = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid_inReady", 64'(i8r), 64'd1);
    chk("rstmid_outValid", 64'(o8v), 64'd0);
    chk("rstmid_product", 64'(p8), 64'd0);
    rstN = 1'b1;
    run8(8'h03, 8'h05, 1'b0, 16'h000F, "u_3_5");

    // Clear any instance left mid-operation before the lockstep random phase.
    rstN = 1'b0;
    @(posedge clk);
    #1 rstN = 1'b1;

    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      chk("rnd_all_ready", 64'(i4r & i8r & i16r & i32r), 64'd1);
      s = 1'($urandom);
      a4 = 4'($urandom);  b4 = 4'($urandom);
      a8 = 8'($urandom);  b8 = 8'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom);
      a32 = $urandom; b32 = $urandom;
      if (n < 4) begin
        a4 = {1'b1, 3'b0}; b4 = '1; a32 = {1'b1, 31'b0}; b32 = (n[0]) ? '1 : {1'b1, 31'b0};
      end
      e4 = ref_mul(4, 32'(a4), 32'(b4), s);
      e8 = ref_mul(8, 32'(a8), 32'(b8), s);
      e16 = ref_mul(16, 32'(a16), 32'(b16), s);
      e32 = ref_mul(32, a32, b32, s);
      v = 1'b1;
      @(posedge clk);
      #1 v = 1'b0;
      d4 = 1'b0; d8 = 1'b0; d16 = 1'b0; d32 = 1'b0;
      cyc = 0;
      while (!(d4 && d8 && d16 && d32) && cyc < 200) begin
        @(negedge clk);
        r = 1'($urandom_range(0, 1));
        if (r && o4v && !d4) begin chk("rnd_w4", 64'(p4), e4); d4 = 1'b1; end
        if (r && o8v && !d8) begin chk("rnd_w8", 64'(p8), e8); d8 = 1'b1; end
        if (r && o16v && !d16) begin chk("rnd_w16", 64'(p16), e16); d16 = 1'b1; end
        if (r && o32v && !d32) begin chk("rnd_w32", p32, e32); d32 = 1'b1; end
        @(posedge clk);
        cyc++;
      end
      #1 r = 1'b0;
      chk("rnd_completed", 64'(d4 & d8 & d16 & d32), 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
